// File: rtl/sysctrl_pkg.sv
// Shared system-control constants used by the IRQ conditioning block.
package sysctrl_pkg;

    localparam int IRQ_BASE       = 7;
    localparam int DEF_DEBOUNCE_W = 8;

    // CPU irq line driven by a given conditioned channel.
    function automatic int cpu_irq_index(input int chan);
        return IRQ_BASE + chan;
    endfunction

endpackage

// File: rtl/sysctrl_irq_cond_if.sv
// Signal bundle between the sysctrl register block / pads and the IRQ conditioner.
interface sysctrl_irq_cond_if #(
    parameter int NUM_IRQ    = 2,
    parameter int DEBOUNCE_W = sysctrl_pkg::DEF_DEBOUNCE_W
);
    // No handshake: all controls are levels, except clr_i, which is a single-cycle
    // pulse acting on the edge where it is high.
    logic [NUM_IRQ-1:0]    irq_src_en_i;
    logic [NUM_IRQ-1:0]    edge_mode_i;
    logic [DEBOUNCE_W-1:0] debounce_lim_i;
    logic [NUM_IRQ-1:0]    pad_irq_i;
    logic [NUM_IRQ-1:0]    clr_i;
    logic [NUM_IRQ-1:0]    irq_o;
    logic [NUM_IRQ-1:0]    filt_o;

    modport master (
        output irq_src_en_i, edge_mode_i, debounce_lim_i, pad_irq_i, clr_i,
        input  irq_o, filt_o
    );

    modport slave (
        input  irq_src_en_i, edge_mode_i, debounce_lim_i, pad_irq_i, clr_i,
        output irq_o, filt_o
    );
endinterface

// File: rtl/sysctrl_irq_cond_chan.sv
// One IRQ channel: pad synchroniser, debounce filter, then level pass or sticky edge capture.
module irq_chan_cond
    import sysctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_W  = DEF_DEBOUNCE_W
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rstn_i,
    input  logic                  en,
    input  logic                  edge_mode,
    input  logic [DEBOUNCE_W-1:0] debounce_lim,
    input  logic                  pad_irq,
    input  logic                  clr,
    output logic                  irq,
    output logic                  filt
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [DEBOUNCE_W-1:0]  cnt_q, cnt_next;
    logic                   filt_q, filt_next;
    logic                   filt_prev_q;
    logic                   mode_prev_q;
    logic                   pending_q, pending_next;
    logic                   irq_q, irq_next;
    logic                   sync;
    logic                   rise;

    assign sync = sync_q[SYNC_STAGES-1];
    assign rise = filt_q & ~filt_prev_q;

    always_comb begin
        cnt_next  = cnt_q;
        filt_next = filt_q;
        if (sync == filt_q) begin
            cnt_next = '0;
        end else if (cnt_q >= debounce_lim) begin
            // >= so a limit lowered mid-count still terminates without wrapping
            filt_next = sync;
            cnt_next  = '0;
        end else begin
            cnt_next = cnt_q + DEBOUNCE_W'(1);
        end
    end

    always_comb begin
        pending_next = en & ((pending_q & ~clr) | rise);
        if (edge_mode != mode_prev_q) begin
            pending_next = 1'b0;
        end
        // irq tracks pending_next so edge-mode irq equals the pending register
        irq_next = edge_mode ? pending_next : (filt_q & en);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            sync_q      <= '0;
            cnt_q       <= '0;
            filt_q      <= 1'b0;
            filt_prev_q <= 1'b0;
            mode_prev_q <= 1'b0;
            pending_q   <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], pad_irq};
            cnt_q       <= cnt_next;
            filt_q      <= filt_next;
            filt_prev_q <= filt_q;
            mode_prev_q <= edge_mode;
            pending_q   <= pending_next;
            irq_q       <= irq_next;
        end
    end

    assign irq  = irq_q;
    assign filt = filt_q;

endmodule

// File: rtl/sysctrl_irq_cond.sv
// Conditions pad IRQs for the CPU (channel 0 feeds IRQ_BASE); one channel instance per bit.
module sysctrl_irq_cond
    import sysctrl_pkg::*;
#(
    parameter int NUM_IRQ     = 2,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_W  = DEF_DEBOUNCE_W
) (
    input  logic                wb_clk_i,
    input  logic                wb_rstn_i,
    sysctrl_irq_cond_if.slave   bus
);

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_chan
        irq_chan_cond #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE_W  (DEBOUNCE_W)
        ) u_chan (
            .wb_clk_i     (wb_clk_i),
            .wb_rstn_i    (wb_rstn_i),
            .en           (bus.irq_src_en_i[g]),
            .edge_mode    (bus.edge_mode_i[g]),
            .debounce_lim (bus.debounce_lim_i),
            .pad_irq      (bus.pad_irq_i[g]),
            .clr          (bus.clr_i[g]),
            .irq          (bus.irq_o[g]),
            .filt         (bus.filt_o[g])
        );
    end

endmodule

// File: tb/tb_sysctrl_irq_cond.sv
// Directed bench for sysctrl_irq_cond: reset, level latency, glitch rejection, edge/clr, enable, mode toggle.
module tb_sysctrl_irq_cond;

    logic wb_clk_i  = 1'b0;
    logic wb_rstn_i = 1'b0;
    int   checks    = 0;
    int   errors    = 0;
    logic seen_f, seen_i;

    sysctrl_irq_cond_if #(.NUM_IRQ(2), .DEBOUNCE_W(8)) bus ();

    sysctrl_irq_cond #(
        .NUM_IRQ     (2),
        .SYNC_STAGES (2),
        .DEBOUNCE_W  (8)
    ) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rstn_i (wb_rstn_i),
        .bus       (bus)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Advance n rising edges, then settle 1 time unit before driving/sampling.
    task automatic step(input int n);
        repeat (n) @(posedge wb_clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.pad_irq_i      = 2'b11;
        bus.irq_src_en_i   = 2'b00;
        bus.edge_mode_i    = 2'b00;
        bus.debounce_lim_i = 8'd3;
        bus.clr_i          = 2'b00;

        // Reset held with pads high
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("rst_irq", 8'(bus.irq_o), 8'h0);
            check("rst_filt", 8'(bus.filt_o), 8'h0);
        end
        bus.pad_irq_i = 2'b00;
        step(1);
        wb_rstn_i = 1'b1;
        step(2);

        // Level mode, L=3: 7-clock latency both directions
        bus.irq_src_en_i = 2'b01;
        bus.pad_irq_i    = 2'b01;
        step(6);
        check("lvl_rise_pre", 8'(bus.irq_o), 8'h0);
        check("lvl_rise_filt", 8'(bus.filt_o), 8'h1);
        step(1);
        check("lvl_rise", 8'(bus.irq_o), 8'h1);
        bus.pad_irq_i = 2'b00;
        step(6);
        check("lvl_fall_pre", 8'(bus.irq_o), 8'h1);
        step(1);
        check("lvl_fall", 8'(bus.irq_o), 8'h0);

        // Glitch of 3 cycles on pad[1] is rejected
        bus.irq_src_en_i = 2'b10;
        seen_f = 1'b0;
        seen_i = 1'b0;
        bus.pad_irq_i = 2'b10;
        for (int i = 0; i < 3; i++) begin
            step(1);
            seen_f |= bus.filt_o[1];
            seen_i |= bus.irq_o[1];
        end
        bus.pad_irq_i = 2'b00;
        for (int i = 0; i < 10; i++) begin
            step(1);
            seen_f |= bus.filt_o[1];
            seen_i |= bus.irq_o[1];
        end
        check("glitch3_filt", 8'(seen_f), 8'h0);
        check("glitch3_irq", 8'(seen_i), 8'h0);

        // 4-cycle pulse passes the filter
        seen_f = 1'b0;
        seen_i = 1'b0;
        bus.pad_irq_i = 2'b10;
        for (int i = 0; i < 4; i++) begin
            step(1);
            seen_f |= bus.filt_o[1];
            seen_i |= bus.irq_o[1];
        end
        bus.pad_irq_i = 2'b00;
        for (int i = 0; i < 12; i++) begin
            step(1);
            seen_f |= bus.filt_o[1];
            seen_i |= bus.irq_o[1];
        end
        check("pulse4_filt", 8'(seen_f), 8'h1);
        check("pulse4_irq", 8'(seen_i), 8'h1);
        check("pulse4_settle", 8'(bus.filt_o), 8'h0);

        // Edge mode, L=0: 4-clock latency, sticky, cleared by clr
        bus.irq_src_en_i   = 2'b01;
        bus.edge_mode_i    = 2'b01;
        bus.debounce_lim_i = 8'd0;
        step(2);
        bus.pad_irq_i = 2'b01;
        step(3);
        check("edge_pre", 8'(bus.irq_o), 8'h0);
        check("edge_filt", 8'(bus.filt_o), 8'h1);
        step(1);
        check("edge_rise", 8'(bus.irq_o), 8'h1);
        step(5);
        check("edge_hold", 8'(bus.irq_o), 8'h1);
        bus.clr_i = 2'b01;
        step(1);
        bus.clr_i = 2'b00;
        check("edge_clr", 8'(bus.irq_o), 8'h0);
        step(2);
        check("edge_clr_stay", 8'(bus.irq_o), 8'h0);

        // Set wins: re-arm pending, then clr coincides with a new rise
        bus.pad_irq_i = 2'b00;
        step(4);
        bus.pad_irq_i = 2'b01;
        step(4);
        check("rearm", 8'(bus.irq_o), 8'h1);
        bus.pad_irq_i = 2'b00;
        step(4);
        check("rearm_fall_filt", 8'(bus.filt_o), 8'h0);
        check("rearm_fall_irq", 8'(bus.irq_o), 8'h1);
        bus.pad_irq_i = 2'b01;
        step(3);
        bus.clr_i = 2'b01;
        step(1);
        bus.clr_i = 2'b00;
        check("set_wins", 8'(bus.irq_o), 8'h1);
        step(1);
        check("set_wins_hold", 8'(bus.irq_o), 8'h1);

        // Enable drop clears, re-raise does not fake an edge
        bus.irq_src_en_i = 2'b00;
        step(1);
        check("en_drop", 8'(bus.irq_o), 8'h0);
        check("en_drop_filt", 8'(bus.filt_o), 8'h1);
        bus.irq_src_en_i = 2'b01;
        step(1);
        check("en_raise", 8'(bus.irq_o), 8'h0);
        step(3);
        check("en_raise_hold", 8'(bus.irq_o), 8'h0);

        // Live mode toggle clears pending
        bus.pad_irq_i = 2'b00;
        step(4);
        bus.pad_irq_i = 2'b01;
        step(4);
        check("mode_arm", 8'(bus.irq_o), 8'h1);
        bus.edge_mode_i = 2'b00;
        step(1);
        check("mode_to_lvl", 8'(bus.irq_o), 8'h1);
        bus.edge_mode_i = 2'b01;
        step(1);
        check("mode_to_edge", 8'(bus.irq_o), 8'h0);

        // Reset in the middle of a debounce count
        bus.edge_mode_i    = 2'b00;
        bus.debounce_lim_i = 8'd3;
        bus.pad_irq_i      = 2'b00;
        step(8);
        check("pre_rst_filt", 8'(bus.filt_o), 8'h0);
        check("pre_rst_irq", 8'(bus.irq_o), 8'h0);
        bus.pad_irq_i = 2'b01;
        step(4);
        wb_rstn_i = 1'b0;
        #1;
        check("mid_rst_irq", 8'(bus.irq_o), 8'h0);
        check("mid_rst_filt", 8'(bus.filt_o), 8'h0);
        bus.pad_irq_i = 2'b00;
        step(2);
        wb_rstn_i = 1'b1;
        seen_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            seen_i |= |bus.irq_o;
        end
        check("post_rst_irq", 8'(seen_i), 8'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
